noc_input_buffer: RTL and testbench

- Per-port input stage of the router. One instance sits in front of each arbiter port (L, N, E, W, S).
- Buffers incoming flits in a small FIFO and tracks packet framing.
- Drives the port's req, flit_id and length inputs to the arbiter and timer.
- Releases flits to the crossbar only while the arbiter grants this port.

---
 rtl/noc_input_buffer.sv | 110 +++++++++++
 tb/tb_noc_input_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_buffer.sv
// rtl/noc_input_buffer.sv - per-port router input stage: flit FIFO, packet framing, arbiter request
module noc_input_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [2:0]            flit_id_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  full,
   input  logic                  grant,
   input  logic                  rd_en,
   output logic                  req,
   output logic [2:0]            flit_id,
   output logic [11:0]           length,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  err_drop
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam logic [2:0]          ID_HDR     = 3'b001;
   localparam logic [2:0]          ID_TAIL    = 3'b100;
   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [2:0]            id_mem   [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [11:0]           pkt_len_q, pkt_len_d;
   state_t                state_q, state_d;
   logic                  err_drop_q, err_drop_d;

   logic [2:0] head_id;
   logic       head_is_hdr, discard, do_wr, do_pop;

   assign empty       = (count_q == '0);
   assign full        = (count_q == FULL_COUNT);
   assign count       = count_q;
   assign head_id     = empty ? 3'b000 : id_mem[rd_ptr_q];
   assign head_is_hdr = (head_id == ID_HDR);
   assign flit_id     = head_id;
   assign data_out    = data_mem[rd_ptr_q];
   assign length      = head_is_hdr ? data_mem[rd_ptr_q][11:0] : pkt_len_q;
   assign err_drop    = err_drop_q;

   // A non-header flit at the head outside a packet is an orphan and is dropped without a grant.
   assign discard = (state_q == IDLE) && !empty && !head_is_hdr;
   assign req     = !empty && ((state_q == ACTIVE) || head_is_hdr);
   assign do_pop  = discard || (rd_en && grant && !empty);
   assign do_wr   = wr_en && !full;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pkt_len_d  = pkt_len_q;
      state_d    = state_q;
      err_drop_d = discard;

      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;

      case ({do_wr, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (do_pop) begin
         if (head_is_hdr) begin
            pkt_len_d = data_mem[rd_ptr_q][11:0];
            state_d   = ACTIVE;
         end else if (state_q == ACTIVE && head_id == ID_TAIL) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pkt_len_q  <= '0;
         state_q    <= IDLE;
         err_drop_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pkt_len_q  <= pkt_len_d;
         state_q    <= state_d;
         err_drop_q <= err_drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         id_mem[wr_ptr_q]   <= flit_id_in;
         data_mem[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_noc_input_buffer.sv
// tb/tb_noc_input_buffer.sv - random and directed checks of noc_input_buffer against a queue model
module tb_noc_input_buffer;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst, wr_en, grant, rd_en;
   logic [2:0]    flit_id_in;
   logic [DW-1:0] data_in;
   logic          full, req, empty, err_drop;
   logic [2:0]    flit_id;
   logic [11:0]   length;
   logic [DW-1:0] data_out;
   logic [AW:0]   count;

   always #5 clk = ~clk;

   noc_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .flit_id_in(flit_id_in), .data_in(data_in),
      .full(full), .grant(grant), .rd_en(rd_en), .req(req), .flit_id(flit_id),
      .length(length), .data_out(data_out), .empty(empty), .count(count), .err_drop(err_drop)
   );

   typedef struct packed {
      logic [2:0]    id;
      logic [DW-1:0] d;
   } flit_t;

   flit_t       q[$];
   bit          m_active;
   logic [11:0] m_len;
   bit          m_err;
   int          checks = 0;
   int          errors = 0;
   int          err_seen;
   bit          req_seen;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_active = 0;
      m_len    = '0;
      m_err    = 0;
   endtask

   // Packet rules applied at each rising edge, using the inputs held across it.
   task automatic model_edge();
      bit    disc, pop, push;
      flit_t h;
      int    n = q.size();
      disc = !m_active && n > 0 && q[0].id != 3'b001;
      pop  = disc || (rd_en && grant && n > 0);
      push = wr_en && n < DEPTH;
      m_err = disc;
      if (pop) begin
         h = q.pop_front();
         if (h.id == 3'b001) begin
            m_len    = h.d[11:0];
            m_active = 1;
         end else if (h.id == 3'b100 && m_active) begin
            m_active = 0;
         end
      end
      if (push) q.push_back('{id: flit_id_in, d: data_in});
   endtask

   task automatic compare_all();
      int         n = q.size();
      logic [2:0] hid;
      hid = (n > 0) ? q[0].id : 3'b000;
      check("empty", empty, n == 0);
      check("full", full, n == DEPTH);
      check("count", count, n);
      check("flit_id", flit_id, hid);
      check("req", req, n > 0 && (m_active || hid == 3'b001));
      check("length", length, (hid == 3'b001) ? q[0].d[11:0] : m_len);
      check("err_drop", err_drop, m_err);
      if (n > 0) check("data_out", data_out, q[0].d);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (err_drop) err_seen++;
      if (req) req_seen = 1;
   endtask

   task automatic drive(input bit w, input logic [2:0] id, input logic [DW-1:0] d,
                        input bit g, input bit r);
      wr_en      = w;
      flit_id_in = id;
      data_in    = d;
      grant      = g;
      rd_en      = r;
      step();
   endtask

   logic [2:0] id_tab [8];

   initial begin
      id_tab = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b011};
      rst = 1'b0; wr_en = 0; grant = 0; rd_en = 0; flit_id_in = '0; data_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_req", req, 1'b0);
      check("rst_flit_id", flit_id, 3'b000);
      check("rst_length", length, 12'h000);
      check("rst_err", err_drop, 1'b0);
      compare_all();

      // header/body/tail then granted drain
      drive(1, 3'b001, 32'hA000_0005, 0, 0);
      drive(1, 3'b010, 32'hB111_1111, 0, 0);
      drive(1, 3'b100, 32'hC222_2222, 0, 0);
      check("t1_count", count, 3);
      check("t1_req", req, 1'b1);
      check("t1_flit_id", flit_id, 3'b001);
      check("t1_length", length, 12'h005);
      repeat (3) drive(0, 3'b000, '0, 1, 1);
      check("t1_empty", empty, 1'b1);
      check("t1_req_off", req, 1'b0);

      // overfill, then simultaneous write/read across pointer wrap
      drive(1, 3'b001, 32'h0000_0009, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 3'b010, 32'h1000_0000 + i, 0, 0);
      check("t2_full", full, 1'b1);
      check("t2_count", count, 4);
      repeat (2) drive(0, 3'b000, '0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         drive(1, 3'b010, 32'h2000_0000 + i, 1, 1);
         check("t2_count_hold", count, 2);
      end
      repeat (2) drive(0, 3'b000, '0, 1, 1);

      // ACTIVE with a bubble: length stays latched
      check("t4_req_bubble", req, 1'b0);
      check("t4_id_bubble", flit_id, 3'b000);
      drive(1, 3'b010, 32'h3333_0FFF, 0, 0);
      check("t4_req", req, 1'b1);
      check("t4_length", length, 12'h009);
      drive(1, 3'b100, 32'h4444_4444, 1, 1);
      repeat (2) drive(0, 3'b000, '0, 1, 1);

      // orphans in IDLE
      err_seen = 0; req_seen = 0;
      drive(1, 3'b010, 32'h5555_5555, 0, 0);
      drive(1, 3'b100, 32'h6666_6666, 0, 0);
      repeat (3) drive(0, 3'b000, '0, 0, 0);
      check("t3_err_pulses", err_seen, 2);
      check("t3_req_never", req_seen, 1'b0);
      check("t3_count", count, 0);

      // rd_en without grant, then async reset mid-packet
      drive(1, 3'b001, 32'h0000_0ABC, 0, 0);
      drive(1, 3'b010, 32'h7777_7777, 1, 1);
      drive(1, 3'b010, 32'h8888_8888, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 3'b000, '0, 0, 1);
         check("t5_count_hold", count, 2);
      end
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("t5_empty", empty, 1'b1);
      check("t5_req", req, 1'b0);
      check("t5_length", length, 12'h000);
      check("t5_err", err_drop, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 3'b000, '0, 0, 0);
      check("t5_err_after", err_drop, 1'b0);

      // header followed by header without tail
      drive(1, 3'b001, 32'h0000_0003, 0, 0);
      drive(1, 3'b001, 32'h0000_0007, 1, 1);
      drive(1, 3'b010, 32'h9999_9999, 1, 1);
      check("t6_length", length, 12'h007);
      check("t6_req", req, 1'b1);
      check("t6_err", err_drop, 1'b0);
      repeat (2) drive(0, 3'b000, '0, 1, 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 2) != 0, id_tab[$urandom_range(0, 7)], $urandom(),
               $urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
